// File: rtl/pipe_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_scheduler: game FSM, two-slot pipe spawn/move/retire, scoring |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_scheduler #(
  parameter int MAX_X         = 320,
  parameter int MIN_X         = 57,
  parameter int PIPE_W        = 41,
  parameter int SPACING       = 140,
  parameter int GAP_MIN       = 180,
  parameter int GAP_MAX       = 280,
  parameter int GAP_DEFAULT   = 205,
  parameter int SPEEDUP_EVERY = 8
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       bird_dead,
  input  logic [9:0] bird_x,
  input  logic [8:0] rand_in,
  output logic [1:0] state,
  output logic [1:0] pipe_vld,
  output logic [9:0] pipe0_l,
  output logic [9:0] pipe1_l,
  output logic [8:0] pipe0_b,
  output logic [8:0] pipe1_b,
  output logic [1:0] velocity,
  output logic [7:0] score,
  output logic       score_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [9:0]  c_max_x       = 10'(MAX_X);
  localparam logic [9:0]  c_spawn_limit = 10'(MAX_X - SPACING);
  localparam logic [10:0] c_pipe_w      = 11'(PIPE_W);
  localparam logic [10:0] c_min_x       = 11'(MIN_X);
  localparam logic [8:0]  c_gap_min     = 9'(GAP_MIN);
  localparam logic [8:0]  c_gap_max     = 9'(GAP_MAX);
  localparam logic [8:0]  c_gap_default = 9'(GAP_DEFAULT);
  localparam logic [7:0]  c_speedup     = 8'(SPEEDUP_EVERY);

  state_t          state_q, state_d;
  logic [1:0]      vld_q, vld_d;
  logic [1:0][9:0] pipe_l_q, pipe_l_d;
  logic [1:0][8:0] pipe_b_q, pipe_b_d;
  logic [1:0]      scored_q, scored_d;
  logic            newest_q, newest_d;
  logic [1:0]      velocity_q, velocity_d;
  logic [7:0]      score_q, score_d;
  logic            pulse_q, pulse_d;

  logic [1:0][10:0] right_edge;
  logic [1:0]       retire;
  logic [1:0]       cand;
  logic [8:0]       gap;
  logic             spawn_ok;
  logic             spawn_slot;
  logic [7:0]       speed_steps;
  logic [1:0]       vel_next;

  // Right edges are 11 bits wide so l + PIPE_W never wraps.
  always_comb begin : comb_helpers
    for (int i = 0; i < 2; i++) begin
      right_edge[i] = {1'b0, pipe_l_q[i]} + c_pipe_w;
      retire[i]     = vld_q[i] && (right_edge[i] <= c_min_x);
      cand[i]       = vld_q[i] && !scored_q[i] && (right_edge[i] < {1'b0, bird_x});
    end
    gap         = ((rand_in >= c_gap_min) && (rand_in <= c_gap_max)) ? rand_in : c_gap_default;
    spawn_ok    = !(&vld_q) && (!(|vld_q) || (pipe_l_q[newest_q] <= c_spawn_limit));
    spawn_slot  = vld_q[0];
    speed_steps = score_q / c_speedup;
    vel_next    = (speed_steps >= 8'd2) ? 2'd3 : (speed_steps[1:0] + 2'd1);
  end

  always_comb begin : comb_next
    state_d    = state_q;
    vld_d      = vld_q;
    pipe_l_d   = pipe_l_q;
    pipe_b_d   = pipe_b_q;
    scored_d   = scored_q;
    newest_d   = newest_q;
    velocity_d = velocity_q;
    score_d    = score_q;
    pulse_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        velocity_d = vel_next;
        if (bird_dead) begin
          state_d = ST_OVER;
        end else begin
          // Only one point per cycle; a second qualifying slot waits a cycle.
          if (cand[0] || cand[1]) begin
            if (cand[0]) scored_d[0] = 1'b1;
            else         scored_d[1] = 1'b1;
            score_d = (score_q == 8'hFF) ? 8'hFF : (score_q + 8'd1);
            pulse_d = 1'b1;
          end
          if (tick) begin
            for (int i = 0; i < 2; i++) begin
              if (retire[i])    vld_d[i]    = 1'b0;
              else if (vld_q[i]) pipe_l_d[i] = pipe_l_q[i] - {8'd0, velocity_q};
            end
            if (spawn_ok) begin
              vld_d[spawn_slot]    = 1'b1;
              pipe_l_d[spawn_slot] = c_max_x;
              pipe_b_d[spawn_slot] = gap;
              scored_d[spawn_slot] = 1'b0;
              newest_d             = spawn_slot;
            end
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d    = ST_IDLE;
          vld_d      = 2'b00;
          pipe_l_d   = {2{c_max_x}};
          pipe_b_d   = {2{c_gap_default}};
          scored_d   = 2'b00;
          newest_d   = 1'b0;
          velocity_d = 2'd1;
          score_d    = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vld_q      <= 2'b00;
      pipe_l_q   <= {2{c_max_x}};
      pipe_b_q   <= {2{c_gap_default}};
      scored_q   <= 2'b00;
      newest_q   <= 1'b0;
      velocity_q <= 2'd1;
      score_q    <= 8'd0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      pipe_l_q   <= pipe_l_d;
      pipe_b_q   <= pipe_b_d;
      scored_q   <= scored_d;
      newest_q   <= newest_d;
      velocity_q <= velocity_d;
      score_q    <= score_d;
      pulse_q    <= pulse_d;
    end
  end

  assign state       = state_q;
  assign pipe_vld    = vld_q;
  assign pipe0_l     = pipe_l_q[0];
  assign pipe1_l     = pipe_l_q[1];
  assign pipe0_b     = pipe_b_q[0];
  assign pipe1_b     = pipe_b_q[1];
  assign velocity    = velocity_q;
  assign score       = score_q;
  assign score_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
`default_nettype none
// tb_pipe_scheduler: directed scenarios plus randomized run against a behavioural game model.
module tb_pipe_scheduler;

  logic       game_clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       bird_dead = 1'b0;
  logic [9:0] bird_x = '0;
  logic [8:0] rand_in = '0;
  logic [1:0] state, pipe_vld, velocity;
  logic [9:0] pipe0_l, pipe1_l;
  logic [8:0] pipe0_b, pipe1_b;
  logic [7:0] score;
  logic       score_pulse;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the game
  int m_state, m_newest, m_vel, m_score, m_pulse;
  int m_vld[2], m_l[2], m_b[2], m_sc[2];

  pipe_scheduler dut (
    .game_clk(game_clk), .reset(reset), .tick(tick), .start(start),
    .bird_dead(bird_dead), .bird_x(bird_x), .rand_in(rand_in),
    .state(state), .pipe_vld(pipe_vld), .pipe0_l(pipe0_l), .pipe1_l(pipe1_l),
    .pipe0_b(pipe0_b), .pipe1_b(pipe1_b), .velocity(velocity), .score(score),
    .score_pulse(score_pulse)
  );

  always #5 game_clk = ~game_clk;

  task automatic model_reset();
    m_state = 0; m_newest = 0; m_vel = 1; m_score = 0; m_pulse = 0;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0; m_l[i] = 320; m_b[i] = 205; m_sc[i] = 0;
    end
  endtask

  task automatic model_step();
    int n_state, n_newest, n_vel, n_score, n_pulse, s, slot;
    int n_vld[2], n_l[2], n_b[2], n_sc[2];
    n_state = m_state; n_newest = m_newest; n_vel = m_vel; n_score = m_score; n_pulse = 0;
    n_vld = m_vld; n_l = m_l; n_b = m_b; n_sc = m_sc;
    if (m_state == 0) begin
      if (start) n_state = 1;
    end else if (m_state == 1) begin
      n_vel = (1 + m_score / 8 > 3) ? 3 : 1 + m_score / 8;
      if (bird_dead) begin
        n_state = 2;
      end else begin
        slot = -1;
        for (int i = 1; i >= 0; i--)
          if (m_vld[i] == 1 && m_sc[i] == 0 && m_l[i] + 41 < int'(bird_x)) slot = i;
        if (slot >= 0) begin
          n_sc[slot] = 1;
          n_score = (m_score >= 255) ? 255 : m_score + 1;
          n_pulse = 1;
        end
        if (tick) begin
          for (int i = 0; i < 2; i++) begin
            if (m_vld[i] == 1 && m_l[i] + 41 <= 57) n_vld[i] = 0;
            else if (m_vld[i] == 1) n_l[i] = m_l[i] - m_vel;
          end
          if ((m_vld[0] == 0 || m_vld[1] == 0) &&
              ((m_vld[0] == 0 && m_vld[1] == 0) || m_l[m_newest] <= 320 - 140)) begin
            s = (m_vld[0] == 0) ? 0 : 1;
            n_vld[s] = 1; n_l[s] = 320; n_sc[s] = 0; n_newest = s;
            n_b[s] = (int'(rand_in) >= 180 && int'(rand_in) <= 280) ? int'(rand_in) : 205;
          end
        end
      end
    end
    m_state = n_state; m_newest = n_newest; m_vel = n_vel; m_score = n_score; m_pulse = n_pulse;
    m_vld = n_vld; m_l = n_l; m_b = n_b; m_sc = n_sc;
    if (m_state == 2 && start && n_state == 2 && !(m_state != 2)) begin
      // OVER restart handled below using the pre-step state
    end
  endtask

  // Wraps model_step so that an OVER->IDLE restart restores every reset value.
  task automatic step();
    int was_over;
    @(posedge game_clk);
    was_over = (m_state == 2 && start) ? 1 : 0;
    model_step();
    if (was_over == 1) model_reset();
    @(negedge game_clk);
  endtask

  task automatic do_reset();
    @(negedge game_clk);
    reset = 1'b1; start = 0; tick = 0; bird_dead = 0;
    model_reset();
    @(negedge game_clk);
    reset = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge game_clk);
    model_reset();
    checks++;
    if ({state, pipe_vld, pipe0_l, pipe1_l, pipe0_b, pipe1_b, velocity, score, score_pulse} !==
        {2'd0, 2'b00, 10'd320, 10'd320, 9'd205, 9'd205, 2'd1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got st=%0d vld=%b l=%0d/%0d b=%0d/%0d v=%0d sc=%0d p=%0d",
               state, pipe_vld, pipe0_l, pipe1_l, pipe0_b, pipe1_b, velocity, score, score_pulse);
    end
    reset = 1'b0;
    step();
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL idle_after_reset: state=%0d want 0", state); end
  endtask

  task automatic test_spawn_spacing();
    do_reset();
    bird_x = 10'd0; rand_in = 9'd230;
    start_run();
    checks++;
    if (state !== 2'd1 || pipe_vld !== 2'b00) begin
      errors++; $display("FAIL start_no_spawn: state=%0d vld=%b want 1/00", state, pipe_vld);
    end
    tick = 1'b1;
    step();
    checks++;
    if (pipe_vld !== 2'b01 || pipe0_l !== 10'd320 || pipe0_b !== 9'd230) begin
      errors++; $display("FAIL first_spawn: vld=%b l0=%0d b0=%0d want 01/320/230", pipe_vld, pipe0_l, pipe0_b);
    end
    repeat (140) step();
    checks++;
    if (pipe_vld !== 2'b01 || pipe0_l !== 10'd180) begin
      errors++; $display("FAIL tick141: vld=%b l0=%0d want 01/180", pipe_vld, pipe0_l);
    end
    step();
    checks++;
    if (pipe_vld !== 2'b11 || pipe1_l !== 10'd320 || pipe0_l !== 10'd179 || pipe1_b !== 9'd230) begin
      errors++; $display("FAIL second_spawn: vld=%b l0=%0d l1=%0d b1=%0d want 11/179/320/230",
                         pipe_vld, pipe0_l, pipe1_l, pipe1_b);
    end
  endtask

  task automatic test_gap_range();
    int vals[7] = '{300, 100, 180, 280, 511, 179, 281};
    int exps[7] = '{205, 205, 180, 280, 205, 205, 205};
    for (int k = 0; k < 7; k++) begin
      do_reset();
      bird_x = 10'd0;
      start_run();
      rand_in = 9'(vals[k]); tick = 1'b1;
      step();
      tick = 1'b0;
      checks++;
      if (pipe0_b !== 9'(exps[k]) || pipe_vld !== 2'b01) begin
        errors++; $display("FAIL gap_%0d: b0=%0d vld=%b want %0d/01", vals[k], pipe0_b, pipe_vld, exps[k]);
      end
    end
  endtask

  task automatic test_retire();
    do_reset();
    bird_x = 10'd0; rand_in = 9'd230;
    start_run();
    tick = 1'b1;
    repeat (305) step();
    checks++;
    if (pipe0_l !== 10'd16 || pipe1_l !== 10'd157 || pipe_vld !== 2'b11) begin
      errors++; $display("FAIL pre_retire: l0=%0d l1=%0d vld=%b want 16/157/11", pipe0_l, pipe1_l, pipe_vld);
    end
    rand_in = 9'd250;
    step();
    checks++;
    if (pipe_vld !== 2'b10 || pipe1_l !== 10'd156) begin
      errors++; $display("FAIL retire: vld=%b l1=%0d want 10/156", pipe_vld, pipe1_l);
    end
    step();
    checks++;
    if (pipe_vld !== 2'b11 || pipe0_l !== 10'd320 || pipe0_b !== 9'd250) begin
      errors++; $display("FAIL reuse_slot0: vld=%b l0=%0d b0=%0d want 11/320/250", pipe_vld, pipe0_l, pipe0_b);
    end
    tick = 1'b0;
  endtask

  task automatic test_score_velocity();
    int thr[3] = '{8, 16, 24};
    int v_at[3] = '{1, 2, 3};
    int v_after[3] = '{2, 3, 3};
    do_reset();
    bird_x = 10'd100; rand_in = 9'd200;
    start_run();
    tick = 1'b1;
    repeat (263) step();
    checks++;
    if (pipe0_l !== 10'd58 || score !== 8'd0 || score_pulse !== 1'b0) begin
      errors++; $display("FAIL pre_score: l0=%0d score=%0d pulse=%0d want 58/0/0", pipe0_l, score, score_pulse);
    end
    step();
    checks++;
    if (score !== 8'd1 || score_pulse !== 1'b1) begin
      errors++; $display("FAIL first_point: score=%0d pulse=%0d want 1/1", score, score_pulse);
    end
    step();
    checks++;
    if (score !== 8'd1 || score_pulse !== 1'b0) begin
      errors++; $display("FAIL pulse_single: score=%0d pulse=%0d want 1/0", score, score_pulse);
    end
    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < 20000 && m_score < thr[t]; n++) step();
      checks++;
      if (score !== 8'(thr[t]) || velocity !== 2'(v_at[t])) begin
        errors++; $display("FAIL vel_at_%0d: score=%0d vel=%0d want %0d/%0d", thr[t], score, velocity, thr[t], v_at[t]);
      end
      step();
      checks++;
      if (velocity !== 2'(v_after[t])) begin
        errors++; $display("FAIL vel_after_%0d: vel=%0d want %0d", thr[t], velocity, v_after[t]);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bird_x = 10'd100; rand_in = 9'd230;
    start_run();
    tick = 1'b1;
    for (int n = 0; n < 5000 && m_score < 5; n++) step();
    checks++;
    if (score !== 8'd5 || state !== 2'd1) begin
      errors++; $display("FAIL reach_score5: score=%0d state=%0d want 5/1", score, state);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({state, pipe_vld, pipe0_l, pipe1_l, pipe0_b, pipe1_b, velocity, score, score_pulse} !==
        {2'd0, 2'b00, 10'd320, 10'd320, 9'd205, 9'd205, 2'd1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got st=%0d vld=%b l=%0d/%0d b=%0d/%0d v=%0d sc=%0d",
               state, pipe_vld, pipe0_l, pipe1_l, pipe0_b, pipe1_b, velocity, score);
    end
    @(negedge game_clk);
    reset = 1'b0; tick = 1'b0;
    step();
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL state_after_release: state=%0d want 0", state); end
  endtask

  task automatic test_death_freeze();
    logic [9:0] l0, l1;
    logic [1:0] vld, vel;
    logic [7:0] sc;
    do_reset();
    bird_x = 10'd100; rand_in = 9'd230;
    start_run();
    tick = 1'b1;
    repeat (300) step();
    l0 = pipe0_l; l1 = pipe1_l; vld = pipe_vld; vel = velocity; sc = score;
    bird_dead = 1'b1;
    step();
    checks++;
    if (state !== 2'd2 || pipe0_l !== l0 || pipe1_l !== l1 || pipe_vld !== vld || score !== sc) begin
      errors++; $display("FAIL death_tick: st=%0d l0=%0d l1=%0d vld=%b sc=%0d want 2/%0d/%0d/%b/%0d",
                         state, pipe0_l, pipe1_l, pipe_vld, score, l0, l1, vld, sc);
    end
    bird_dead = 1'b0;
    repeat (10) step();
    checks++;
    if (state !== 2'd2 || pipe0_l !== l0 || pipe1_l !== l1 || pipe_vld !== vld ||
        score !== sc || velocity !== vel || score_pulse !== 1'b0) begin
      errors++; $display("FAIL over_freeze: st=%0d l0=%0d l1=%0d vld=%b sc=%0d v=%0d",
                         state, pipe0_l, pipe1_l, pipe_vld, score, velocity);
    end
    tick = 1'b0; start = 1'b1;
    step();
    checks++;
    if (state !== 2'd0 || score !== 8'd0 || pipe_vld !== 2'b00 || pipe0_l !== 10'd320 ||
        pipe1_b !== 9'd205 || velocity !== 2'd1) begin
      errors++; $display("FAIL over_restart: st=%0d sc=%0d vld=%b l0=%0d b1=%0d v=%0d want 0/0/00/320/205/1",
                         state, score, pipe_vld, pipe0_l, pipe1_b, velocity);
    end
    step();
    start = 1'b0;
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL one_cycle_idle: state=%0d want 1", state); end
  endtask

  task automatic test_random();
    int extra;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        do_reset();
        start_run();
      end
      extra = 0;
      for (int n = 0; n < 40000; n++) begin
        tick      = ($urandom_range(0, 3) != 0);
        rand_in   = 9'($urandom_range(0, 511));
        bird_x    = 10'($urandom_range(0, 400));
        start     = (ph == 0) && ($urandom_range(0, 15) == 0);
        bird_dead = (ph == 0) && ($urandom_range(0, 63) == 0);
        step();
        checks++;
        if (state !== 2'(m_state) || pipe_vld !== {1'(m_vld[1]), 1'(m_vld[0])} ||
            pipe0_l !== 10'(m_l[0]) || pipe1_l !== 10'(m_l[1]) ||
            pipe0_b !== 9'(m_b[0]) || pipe1_b !== 9'(m_b[1]) || velocity !== 2'(m_vel) ||
            score !== 8'(m_score) || score_pulse !== 1'(m_pulse)) begin
          errors++;
          $display("FAIL random_cycle_%0d: got st=%0d vld=%b l=%0d/%0d b=%0d/%0d v=%0d sc=%0d p=%0d want st=%0d vld=%0d%0d l=%0d/%0d b=%0d/%0d v=%0d sc=%0d p=%0d",
                   n, state, pipe_vld, pipe0_l, pipe1_l, pipe0_b, pipe1_b, velocity, score, score_pulse,
                   m_state, m_vld[1], m_vld[0], m_l[0], m_l[1], m_b[0], m_b[1], m_vel, m_score, m_pulse);
        end
        if (errors > 40) break;
        if (ph == 0 && n == 3999) break;
        if (ph == 1 && m_score == 255) extra++;
        if (extra > 300) break;
      end
      if (ph == 1) begin
        checks++;
        if (score !== 8'd255) begin errors++; $display("FAIL score_saturate: score=%0d want 255", score); end
      end
    end
    tick = 1'b0; start = 1'b0; bird_dead = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spawn_spacing();
    test_gap_range();
    test_retire();
    test_score_velocity();
    test_reset_mid_run();
    test_death_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
